// File: rtl/alu.sv
// alu: 16-bit add/sub/AND/NOT-B unit with combinational zero flag and a {V,N,Z} status register.
// Optional V/N status bits are built only when ALU_STATUS_NV_EN is defined.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Ain,
    input  logic [15:0] Bin,
    input  logic [1:0]  ALUop,
    input  logic        load_status,
    output logic [15:0] out,
    output logic        Z,
    output logic [2:0]  status
);
    logic [15:0] b_op;
    logic [15:0] sum;
    logic [2:0]  flags;
    // Subtraction reuses the adder as Ain + ~Bin + 1.
    always_comb begin
        b_op = ALUop[0] ? ~Bin : Bin;
        sum = Ain + b_op + {15'b0, ALUop[0]};
        out = ALUop[1] ? (ALUop[0] ? ~Bin : Ain & Bin) : sum;
        Z = out == 16'h0000;
`ifdef ALU_STATUS_NV_EN
        flags = {~ALUop[1] & (Ain[15] == b_op[15]) & (sum[15] != Ain[15]), out[15], Z};
`else
        flags = {2'b00, Z};
`endif
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) status <= 3'b000;
        else if (load_status) status <= flags;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed test-plan vectors plus random operations checked against an arithmetic reference model.
module tb_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] Ain = '0;
    logic [15:0] Bin = '0;
    logic [1:0]  ALUop = '0;
    logic        load_status = 1'b0;
    logic [15:0] out;
    logic        Z;
    logic [2:0]  status;
    int tests = 0;
    int fails = 0;
    logic [2:0] exp_status = 3'b000;

    alu dut (
        .clk(clk), .reset(reset), .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
        .load_status(load_status), .out(out), .Z(Z), .status(status)
    );

    always #5 clk = ~clk;

    // Returns {V, N, Z, out} from signed integer arithmetic.
    function automatic logic [18:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        int sa, sb, r;
        logic [15:0] o;
        logic v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 0;
        v = 1'b0;
        if (op == 2'd0) r = sa + sb;
        else if (op == 2'd1) r = sa - sb;
        if (op[1] == 1'b0) begin
            o = r[15:0];
            v = (r > 32767) || (r < -32768);
        end else if (op == 2'd2) o = a & b;
        else o = ~b;
`ifdef ALU_STATUS_NV_EN
        return {v, o[15], o == 16'h0000, o};
`else
        return {2'b00, o == 16'h0000, o};
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic comb(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic [15:0] exp_out);
        logic [18:0] m;
        Ain = a; Bin = b; ALUop = op;
        #1;
        m = ref_alu(a, b, op);
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_z"}, {15'b0, Z}, {15'b0, exp_out == 16'h0000});
        chk({tag, "_model"}, out, m[15:0]);
    endtask

    task automatic capture(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           input logic ld);
        logic [18:0] m;
        @(negedge clk);
        Ain = a; Bin = b; ALUop = op; load_status = ld;
        m = ref_alu(a, b, op);
        @(posedge clk);
        if (ld && !reset) exp_status = m[18:16];
        #1;
        load_status = 1'b0;
        chk(tag, {13'b0, status}, {13'b0, exp_status});
    endtask

    initial begin
        logic [18:0] m;
        #2;
        reset = 1'b1;
        #1;
        chk("reset_imm", {13'b0, status}, 16'h0000);
        comb("add_3_2", 16'd3, 16'd2, 2'b00, 16'd5);
        comb("add_5_9", 16'd5, 16'd9, 2'b00, 16'd14);
        comb("add_wrap", 16'hFFFF, 16'd2, 2'b00, 16'h0001);
        comb("add_zero", 16'd0, 16'd0, 2'b00, 16'h0000);
        comb("sub_20_19", 16'd20, 16'd19, 2'b01, 16'd1);
        comb("sub_15_5", 16'd15, 16'd5, 2'b01, 16'd10);
        comb("sub_borrow", 16'd1, 16'd2, 2'b01, 16'hFFFF);
        comb("sub_zero", 16'd3, 16'd3, 2'b01, 16'h0000);
        comb("and_same", 16'h8A5F, 16'h8A5F, 2'b10, 16'h8A5F);
        comb("and_mix", 16'hF566, 16'h6FF6, 2'b10, 16'h6566);
        comb("and_zero", 16'hFFFF, 16'h0000, 2'b10, 16'h0000);
        comb("notb_1", 16'd5, 16'hD5D3, 2'b11, 16'h2A2C);
        comb("notb_2", 16'd24, 16'hCEB6, 2'b11, 16'h3149);
        comb("notb_zero", 16'd38, 16'hFFFF, 2'b11, 16'h0000);
        capture("reset_ignores_load", 16'd3, 16'd3, 2'b01, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        capture("release_capture_ovf", 16'h7FFF, 16'd1, 2'b00, 1'b1);
`ifdef ALU_STATUS_NV_EN
        chk("ovf_const", {13'b0, status}, 16'h0006);
`else
        chk("ovf_const", {13'b0, status}, 16'h0000);
`endif
        capture("hold", 16'd3, 16'd3, 2'b01, 1'b0);
        capture("capture_zero", 16'd3, 16'd3, 2'b01, 1'b1);
        chk("zero_const", {13'b0, status}, 16'h0001);
        capture("sub_ovf", 16'h8000, 16'd1, 2'b01, 1'b1);
        capture("sub_neg", 16'd1, 16'd2, 2'b01, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_status = 3'b000;
        #1;
        chk("reset_mid", {13'b0, status}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a, b;
            logic [1:0] op;
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 8 == 0) b = a;
            if (i % 8 == 1) a = 16'h7FFF ^ 16'($urandom_range(0, 3));
            op = 2'($urandom_range(0, 3));
            m = ref_alu(a, b, op);
            @(negedge clk);
            Ain = a; Bin = b; ALUop = op;
            #1;
            chk("rand_out", out, m[15:0]);
            chk("rand_z", {15'b0, Z}, {15'b0, m[16]});
            capture("rand_status", a, b, op, 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
